// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM sequencer port between the ROM loader,
// PPU CHR fetches and CPU PRG fetches, one access at a time.
// Fixed priority LD > CHR > PRG, with a starvation guard that lets PRG beat
// CHR after STARVE_MAX back-to-back CHR grants made while PRG was waiting.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; choose a winner and latch its command
// REQ   | mem_req high, waiting for the sequencer to accept (mem_ack)
// WAIT  | command accepted, waiting for mem_done / mem_rdata
// DONE  | one-cycle done pulse to the owner, then back to IDLE
module sdram_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              ld_req,
  input  logic              chr_req,
  input  logic              prg_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic              ld_we,
  input  logic              chr_we,
  input  logic              prg_we,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] chr_wdata,
  input  logic [DATA_W-1:0] prg_wdata,
  output logic              ld_done,
  output logic              chr_done,
  output logic              prg_done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LD   = 2'd1;
  localparam logic [1:0] G_CHR  = 2'd2;
  localparam logic [1:0] G_PRG  = 2'd3;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state;
  logic [7:0] starve_cnt;
  logic [1:0] pick;

  // Winner for a grant made in IDLE; PRG overtakes CHR once starved.
  always_comb begin
    pick = G_NONE;
    if (ld_req)
      pick = G_LD;
    else if (prg_req && (!chr_req || starve_cnt == STARVE_LIM))
      pick = G_PRG;
    else if (chr_req)
      pick = G_CHR;
  end

  // Access sequencing, command latching, done pulses and starvation count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      ld_done    <= 1'b0;
      chr_done   <= 1'b0;
      prg_done   <= 1'b0;
      rdata_out  <= '0;
      grant_out  <= G_NONE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          case (pick)
            G_LD: begin
              mem_addr  <= ld_addr;
              mem_we    <= ld_we;
              mem_wdata <= ld_wdata;
            end
            G_CHR: begin
              mem_addr  <= chr_addr;
              mem_we    <= chr_we;
              mem_wdata <= chr_wdata;
              if (!prg_req)
                starve_cnt <= '0;
              else if (starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;
            end
            G_PRG: begin
              mem_addr   <= prg_addr;
              mem_we     <= prg_we;
              mem_wdata  <= prg_wdata;
              starve_cnt <= '0;
            end
            default: begin
              if (!prg_req)
                starve_cnt <= '0;
            end
          endcase
          if (pick != G_NONE) begin
            grant_out <= pick;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            rdata_out <= mem_rdata;
            ld_done   <= (grant_out == G_LD);
            chr_done  <= (grant_out == G_CHR);
            prg_done  <= (grant_out == G_PRG);
            state     <= DONE;
          end
        end
        DONE: begin
          ld_done   <= 1'b0;
          chr_done  <= 1'b0;
          prg_done  <= 1'b0;
          grant_out <= G_NONE;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter with a small
// sequencer model; expected accesses are queued when requests are raised
// and compared when the matching done pulse appears.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;

  localparam logic [1:0] G_LD  = 2'd1;
  localparam logic [1:0] G_CHR = 2'd2;
  localparam logic [1:0] G_PRG = 2'd3;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              ld_req, chr_req, prg_req;
  logic [ADDR_W-1:0] ld_addr, chr_addr, prg_addr;
  logic              ld_we, chr_we, prg_we;
  logic [DATA_W-1:0] ld_wdata, chr_wdata, prg_wdata;
  logic              ld_done, chr_done, prg_done;
  logic [DATA_W-1:0] rdata_out;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack, mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant_out;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .ld_req(ld_req), .chr_req(chr_req), .prg_req(prg_req),
    .ld_addr(ld_addr), .chr_addr(chr_addr), .prg_addr(prg_addr),
    .ld_we(ld_we), .chr_we(chr_we), .prg_we(prg_we),
    .ld_wdata(ld_wdata), .chr_wdata(chr_wdata), .prg_wdata(prg_wdata),
    .ld_done(ld_done), .chr_done(chr_done), .prg_done(prg_done),
    .rdata_out(rdata_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .grant_out(grant_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]        src;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]        src;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   ack_delay  = 0;
  int   done_delay = 3;
  bit   seq_stray  = 1'b0;

  // Sequencer read data is a fixed function of the address it was given.
  function automatic logic [DATA_W-1:0] model_rdata(input logic [ADDR_W-1:0] a);
    return a[7:0] + 8'h82;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] src, input logic [ADDR_W-1:0] a,
                          input logic we, input logic [DATA_W-1:0] wd);
    exp_t e;
    e.src = src; e.addr = a; e.we = we; e.wdata = wd; e.rdata = model_rdata(a);
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input logic [1:0] src, input logic [ADDR_W-1:0] a,
                           input logic we, input logic [DATA_W-1:0] wd);
    case (src)
      G_LD:    begin ld_req = 1'b1;  ld_addr = a;  ld_we = we;  ld_wdata = wd;  end
      G_CHR:   begin chr_req = 1'b1; chr_addr = a; chr_we = we; chr_wdata = wd; end
      default: begin prg_req = 1'b1; prg_addr = a; prg_we = we; prg_wdata = wd; end
    endcase
  endtask

  task automatic raise(input logic [1:0] src, input logic [ADDR_W-1:0] a,
                       input logic we, input logic [DATA_W-1:0] wd);
    push_exp(src, a, we, wd);
    drive_req(src, a, we, wd);
  endtask

  // Wait for n done pulses, dropping each requester in its done cycle.
  task automatic serve(input int n, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk_in);
      if (ld_done)  begin ld_req = 1'b0;  seen++; end
      if (chr_done) begin chr_req = 1'b0; seen++; end
      if (prg_done) begin prg_req = 1'b0; seen++; end
    end
    chk("serve_done_count", 64'(seen), 64'(n));
  endtask

  // Sequencer model: acks after ack_delay REQ cycles, done done_delay later.
  initial begin : seq_model
    int phase;
    int cnt;
    phase = 0; cnt = 0;
    mem_ack = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk_in);
      mem_ack = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      if (!rst_n_in) phase = 0;
      else begin
        case (phase)
          0: if (mem_req) begin
               if (ack_delay == 0) begin mem_ack = 1'b1; cnt = done_delay; phase = 2; end
               else begin cnt = ack_delay; phase = 1; end
             end
          1: begin
               cnt--;
               if (seq_stray && cnt == 2) begin mem_done = 1'b1; mem_rdata = 8'hEE; end
               if (cnt == 0) begin mem_ack = 1'b1; cnt = done_delay; phase = 2; end
             end
          default: begin
               cnt--;
               if (seq_stray && cnt == 2) mem_ack = 1'b1;
               if (cnt == 0) begin
                 mem_done = 1'b1; mem_rdata = model_rdata(mem_addr); phase = 0;
               end
             end
        endcase
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest queued access.
  initial begin : monitor
    exp_t       e;
    logic [1:0] who;
    int         n_hi;
    forever begin
      @(negedge clk_in);
      n_hi = int'(ld_done) + int'(chr_done) + int'(prg_done);
      if (n_hi != 0) begin
        chk("done_onehot", 64'(n_hi), 64'd1);
        who = ld_done ? G_LD : (chr_done ? G_CHR : G_PRG);
        if (sb_q.size() == 0) chk("unexpected_done", 64'(who), 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("done_owner", 64'(who), 64'(e.src));
          chk("grant_in_done", 64'(grant_out), 64'(e.src));
          chk("mem_addr_held", 64'(mem_addr), 64'(e.addr));
          chk("mem_we_held", 64'(mem_we), 64'(e.we));
          if (e.we) chk("mem_wdata_held", 64'(mem_wdata), 64'(e.wdata));
          chk("rdata_out", 64'(rdata_out), 64'(e.rdata));
        end
      end
    end
  end

  initial begin : main
    vec_t vecs[6];
    int   req_cycles, seen, cnt;
    int   max_st;
    bit   prg_chk, got;

    vecs[0] = '{G_LD,  22'h000000, 1'b0, 8'h00};
    vecs[1] = '{G_CHR, 22'h3FFFFF, 1'b1, 8'hFF};
    vecs[2] = '{G_PRG, 22'h155555, 1'b1, 8'h01};
    vecs[3] = '{G_LD,  22'h2AAAAA, 1'b1, 8'h80};
    vecs[4] = '{G_CHR, 22'h000456, 1'b0, 8'h00};
    vecs[5] = '{G_PRG, 22'h3FFFFF, 1'b0, 8'h00};

    ld_req = 0; chr_req = 0; prg_req = 0;
    ld_addr = '0; chr_addr = '0; prg_addr = '0;
    ld_we = 0; chr_we = 0; prg_we = 0;
    ld_wdata = '0; chr_wdata = '0; prg_wdata = '0;

    // Reset values
    rst_n_in = 1'b1;
    #1 rst_n_in = 1'b0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_grant", 64'(grant_out), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_dones", 64'({ld_done, chr_done, prg_done}), 64'd0);
    chk("rst_rdata", 64'(rdata_out), 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Single PRG read with exact latency
    @(negedge clk_in);
    raise(G_PRG, 22'h000123, 1'b0, 8'h00);
    @(negedge clk_in);
    chk("t1_mem_req_hi", 64'(mem_req), 64'd1);
    chk("t1_grant_prg", 64'(grant_out), 64'd3);
    chk("t1_mem_addr", 64'(mem_addr), 64'h000123);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk_in);
    chk("t1_mem_req_lo", 64'(mem_req), 64'd0);
    repeat (2) @(negedge clk_in);
    chk("t1_no_early_done", 64'(prg_done), 64'd0);
    @(negedge clk_in);
    chk("t1_prg_done", 64'(prg_done), 64'd1);
    chk("t1_rdata", 64'(rdata_out), 64'hA5);
    prg_req = 1'b0;
    @(negedge clk_in);
    chk("t1_done_single", 64'(prg_done), 64'd0);
    chk("t1_grant_idle", 64'(grant_out), 64'd0);

    // Table of single accesses
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      raise(vecs[i].src, vecs[i].addr, vecs[i].we, vecs[i].wdata);
      serve(1, 40);
    end

    // Simultaneous LD, CHR, PRG: served in that order
    @(negedge clk_in);
    raise(G_LD,  22'h010000, 1'b0, 8'h00);
    raise(G_CHR, 22'h020000, 1'b0, 8'h00);
    raise(G_PRG, 22'h030000, 1'b0, 8'h00);
    serve(3, 60);

    // LD write at top address with CHR raised behind it
    @(negedge clk_in);
    raise(G_LD, 22'h3FFFFF, 1'b1, 8'h5A);
    @(negedge clk_in);
    chk("t4_grant_ld", 64'(grant_out), 64'd1);
    chk("t4_mem_we", 64'(mem_we), 64'd1);
    chk("t4_mem_wdata", 64'(mem_wdata), 64'h5A);
    raise(G_CHR, 22'h000777, 1'b0, 8'h00);
    serve(2, 60);

    // Starvation guard: CHR held, PRG held
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) push_exp(G_CHR, 22'h004000, 1'b0, 8'h00);
    push_exp(G_PRG, 22'h008000, 1'b0, 8'h00);
    push_exp(G_CHR, 22'h004000, 1'b0, 8'h00);
    drive_req(G_CHR, 22'h004000, 1'b0, 8'h00);
    drive_req(G_PRG, 22'h008000, 1'b0, 8'h00);
    max_st = 0; prg_chk = 1'b0; seen = 0;
    for (int c = 0; c < 200 && seen < 6; c++) begin
      @(negedge clk_in);
      if (int'(dut.starve_cnt) > max_st) max_st = int'(dut.starve_cnt);
      if (grant_out == G_PRG && !prg_chk) begin
        prg_chk = 1'b1;
        chk("t3_starve_clear", 64'(dut.starve_cnt), 64'd0);
      end
      if (chr_done) begin seen++; if (seen == 6) chr_req = 1'b0; end
      if (prg_done) begin seen++; prg_req = 1'b0; end
    end
    chk("t3_done_count", 64'(seen), 64'd6);
    chk("t3_prg_granted", 64'(prg_chk), 64'd1);
    chk("t3_starve_peak", 64'(max_st), 64'(STARVE_MAX));

    // Delayed ack with stray mem_done during REQ and stray mem_ack during WAIT
    ack_delay = 5; seq_stray = 1'b1;
    @(negedge clk_in);
    raise(G_PRG, 22'h2ABCDE, 1'b0, 8'h00);
    req_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (mem_req) begin
        req_cycles++;
        chk("t6_addr_hold", 64'(mem_addr), 64'h2ABCDE);
      end else if (req_cycles > 0) break;
    end
    chk("t6_req_cycles", 64'(req_cycles), 64'd6);
    serve(1, 30);
    ack_delay = 0; seq_stray = 1'b0;

    // Reset during WAIT abandons the access
    done_delay = 20;
    @(negedge clk_in);
    drive_req(G_PRG, 22'h0ABCDE, 1'b0, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk_in);
      got = mem_req;
    end
    chk("t5_req_seen", 64'(got), 64'd1);
    @(negedge clk_in);
    chk("t5_in_wait", 64'(mem_req), 64'd0);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t5_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t5_rst_grant", 64'(grant_out), 64'd0);
    chk("t5_rst_dones", 64'({ld_done, chr_done, prg_done}), 64'd0);
    prg_req = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    done_delay = 3;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_in);
      if (ld_done || chr_done || prg_done) cnt++;
    end
    chk("t5_no_stale_done", 64'(cnt), 64'd0);
    @(negedge clk_in);
    raise(G_PRG, 22'h0ABCDE, 1'b0, 8'h00);
    serve(1, 40);

    repeat (3) @(negedge clk_in);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port inside the cartridge emulator between three requesters: the ROM loader (I2C boot copy), PPU CHR fetches and CPU PRG fetches. It performs one access at a time through a req/ack/done handshake, with fixed priority and a starvation guard so PRG is never locked out by back-to-back CHR traffic. It sits between the cartridge address decode and the SDRAM command sequencer, in the `clk_sdram` domain.

## Interface
Parameters:
- `ADDR_W`, 22, SDRAM byte address width.
- `DATA_W`, 8, data width.
- `STARVE_MAX`, 8, consecutive CHR grants with PRG waiting before PRG is forced to win (range 1..255).

Ports:
- `clk_in`, in, 1, clock; all logic on the rising edge.
- `rst_n_in`, in, 1, reset, asynchronous, active-low.
- `ld_req`, `chr_req`, `prg_req`, in, 1 each, level request, held until the matching done.
- `ld_addr`, `chr_addr`, `prg_addr`, in, ADDR_W each, access address, stable while req is high.
- `ld_we`, `chr_we`, `prg_we`, in, 1 each, 1 = write.
- `ld_wdata`, `chr_wdata`, `prg_wdata`, in, DATA_W each, write data.
- `ld_done`, `chr_done`, `prg_done`, out, 1 each, one-cycle completion pulse.
- `rdata_out`, out, DATA_W, read data, valid in the cycle any done is high.
- `mem_req`, out, 1, request to the sequencer.
- `mem_addr`, out, ADDR_W, latched address.
- `mem_we`, out, 1, latched write enable.
- `mem_wdata`, out, DATA_W, latched write data.
- `mem_ack`, in, 1, one-cycle pulse: sequencer accepted the command.
- `mem_done`, in, 1, one-cycle pulse: access finished; `mem_rdata` valid.
- `mem_rdata`, in, DATA_W, read data from the sequencer.
- `grant_out`, out, 2, owner of the current access: 0 none, 1 LD, 2 CHR, 3 PRG.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if any req is high, pick a winner; latch its addr/we/wdata into the mem_* registers and set grant_out; go to REQ. Otherwise stay.
- Priority: LD > CHR > PRG. Exception: if `starve_cnt == STARVE_MAX` and `prg_req` is high, PRG beats CHR. LD always wins.
- `starve_cnt` (8 bit):
  - Increments, saturating at STARVE_MAX, on each CHR grant made while `prg_req` is high.
  - Clears on a PRG grant, or in any IDLE cycle with `prg_req` low.
  - LD grants leave it unchanged.
- REQ: `mem_req` = 1. On `mem_ack`, go to WAIT and drop `mem_req` on the next edge.
- WAIT: `mem_req` = 0. On `mem_done`, capture `mem_rdata` into `rdata_out` and go to DONE.
- DONE: assert the done pulse for the granted requester for exactly one cycle, then go to IDLE. grant_out returns to 0 in IDLE.
- `mem_done` or `mem_ack` arriving outside WAIT or REQ respectively is ignored.
- A requester must drop req on the edge that ends its done cycle. A req still high in IDLE is treated as a new access.
- Writes still produce a done pulse. `rdata_out` then holds whatever `mem_rdata` carried.
- Requests raised after a grant wait. Grant choice is made only in IDLE.

## Timing
- Reset (async, immediate) values: state IDLE, `mem_req` 0, `mem_addr`/`mem_we`/`mem_wdata` 0, all done signals 0, `rdata_out` 0, `grant_out` 0, `starve_cnt` 0.
- Reset asserted mid-access abandons the access. `mem_req` falls without waiting for a clock edge. The sequencer is reset by the same signal.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency, counting the edge that samples req in IDLE as edge 0:
  - `mem_req` is high after edge 0.
  - If `mem_ack` is high in that first cycle, WAIT follows edge 1.
  - If `mem_done` arrives in the cycle after edge N, done is high after edge N+1 and IDLE is reached after edge N+2.
- Minimum spacing between grants is 4 cycles (IDLE, REQ, WAIT, DONE).
- `mem_addr`, `mem_we` and `mem_wdata` stay stable from entry into REQ until leaving DONE.

## Test plan
- Single PRG read at `addr`=0x00123. Sequencer acks in the 1st REQ cycle and returns done with 0xA5 three cycles later. Required: `mem_addr`=0x00123, `mem_we`=0, `prg_done` pulses once with `rdata_out`=0xA5, `grant_out` sequence 3 then 0.
- LD, CHR and PRG requests raised in the same cycle. Required: service order LD, CHR, PRG, with exactly one done pulse each.
- `STARVE_MAX`=4; `chr_req` re-raised immediately after every done while `prg_req` is held. Required: 4 CHR grants, then PRG, then CHR again, with `starve_cnt` 0 after the PRG grant.
- LD write to 0x3FFFFF with data 0x5A. Required: `mem_we`=1, `mem_wdata`=0x5A, `ld_done` pulse; CHR requests pending meanwhile are granted only afterwards.
- `rst_n_in` asserted in WAIT, then released. Required: `mem_req`/done/`grant_out` are 0 immediately; no done pulse for the abandoned access; a fresh PRG request then completes normally.
- `mem_ack` delayed 5 cycles and a stray `mem_done` injected during REQ. Required: the stray `mem_done` is ignored and `mem_addr` is held through the delay.
